// File: rtl/pll_led_sequencer.sv
// Avalon-MM slave that sequences PLL reset and lock acquisition, then drives a
// programmable LED blinker from the locked system clock and exports status/counters.
module pll_led_sequencer #(
    parameter int RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int CNT_W           = 24,
    parameter int HALF_PERIOD_RST = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        pll_locked,
    output logic        pll_areset,
    output logic        LED
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HP_RST  = CNT_W'(HALF_PERIOD_RST);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    state_t            fsm_next;
    logic              sync_meta;
    logic              locked_s;
    logic [RC_W-1:0]   rst_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              led_en;
    logic              timeout_sticky;
    logic              lostlock_sticky;
    logic [CNT_W-1:0]  half_period;
    logic [CNT_W-1:0]  hp_m1;
    logic [CNT_W-1:0]  blink_cnt;
    logic [15:0]       toggles;
    logic              set_timeout;
    logic              set_lostlock;
    logic              enter_rst;
    logic              blink_run;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_hp;
    logic              start;
    logic [31:0]       rd_mux;

    assign wr_ctrl   = write && (address == 2'd0);
    assign wr_status = write && (address == 2'd1);
    assign wr_hp     = write && (address == 2'd2);
    assign start     = wr_ctrl && writedata[1];

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state logic; sticky sets are raised even when start overrides the move
    always_comb begin
        fsm_next     = state;
        next_state   = state;
        set_timeout  = 1'b0;
        set_lostlock = 1'b0;
        case (state)
            ST_RST: begin
                if (rst_cnt == RC_LAST) begin
                    fsm_next = ST_WAIT;
                end else begin
                    fsm_next = ST_RST;
                end
            end
            ST_WAIT: begin
                if (locked_s) begin
                    fsm_next = ST_RUN;
                end else if (to_cnt == TO_LAST) begin
                    fsm_next    = ST_FAIL;
                    set_timeout = 1'b1;
                end else begin
                    fsm_next = ST_WAIT;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    fsm_next     = ST_RST;
                    set_lostlock = 1'b1;
                end else begin
                    fsm_next = ST_RUN;
                end
            end
            ST_FAIL: fsm_next = ST_FAIL;
            default: fsm_next = ST_RST;
        endcase
        if (start) begin
            next_state = ST_RST;
        end else begin
            next_state = fsm_next;
        end
    end

    assign enter_rst = (next_state == ST_RST) && ((state != ST_RST) || start);
    // Blinker stops in the same cycle the FSM decides to leave RUN, so LED is low on RST entry
    assign blink_run = (state == ST_RUN) && (next_state == ST_RUN) && led_en;
    assign hp_m1     = (half_period == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (half_period - CNT_W'(1));

    // State register, restart counters and PLL reset output
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RST;
            rst_cnt    <= {RC_W{1'b0}};
            to_cnt     <= {TO_W{1'b0}};
            pll_areset <= 1'b1;
        end else begin
            state      <= next_state;
            pll_areset <= (next_state == ST_RST);
            if (enter_rst) begin
                rst_cnt <= {RC_W{1'b0}};
                to_cnt  <= {TO_W{1'b0}};
            end else if (state == ST_RST) begin
                rst_cnt <= rst_cnt + RC_W'(1);
                to_cnt  <= to_cnt;
            end else if (state == ST_WAIT) begin
                rst_cnt <= rst_cnt;
                to_cnt  <= to_cnt + TO_W'(1);
            end else begin
                rst_cnt <= rst_cnt;
                to_cnt  <= to_cnt;
            end
        end
    end

    // Software-visible control, sticky status and half-period registers
    always_ff @(posedge clock) begin
        if (reset) begin
            led_en          <= 1'b0;
            timeout_sticky  <= 1'b0;
            lostlock_sticky <= 1'b0;
            half_period     <= HP_RST;
        end else begin
            led_en      <= wr_ctrl ? writedata[0] : led_en;
            half_period <= wr_hp ? writedata[CNT_W-1:0] : half_period;
            if (set_timeout) begin
                timeout_sticky <= 1'b1;
            end else if (wr_status && writedata[3]) begin
                timeout_sticky <= 1'b0;
            end else begin
                timeout_sticky <= timeout_sticky;
            end
            if (set_lostlock) begin
                lostlock_sticky <= 1'b1;
            end else if (wr_status && writedata[4]) begin
                lostlock_sticky <= 1'b0;
            end else begin
                lostlock_sticky <= lostlock_sticky;
            end
        end
    end

    // LED blinker and toggle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt <= {CNT_W{1'b0}};
            LED       <= 1'b0;
            toggles   <= 16'd0;
        end else if (blink_run) begin
            if (blink_cnt >= hp_m1) begin
                blink_cnt <= {CNT_W{1'b0}};
                LED       <= ~LED;
                toggles   <= start ? 16'd0 : (toggles + 16'd1);
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
                LED       <= LED;
                toggles   <= start ? 16'd0 : toggles;
            end
        end else begin
            blink_cnt <= {CNT_W{1'b0}};
            LED       <= 1'b0;
            toggles   <= start ? 16'd0 : toggles;
        end
    end

    // Read data mux
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            2'd0:    rd_mux = {31'd0, led_en};
            2'd1:    rd_mux = {27'd0, lostlock_sticky, timeout_sticky, locked_s, state};
            2'd2:    rd_mux = 32'(half_period);
            2'd3:    rd_mux = {16'd0, toggles};
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata <= 32'd0;
        end else if (read) begin
            readdata <= rd_mux;
        end else begin
            readdata <= readdata;
        end
    end

endmodule

// File: tb/tb_pll_led_sequencer.sv
// Directed testbench for pll_led_sequencer: reset, timeout, lock, blinking,
// lock loss, start priority and sticky-bit races.
module tb_pll_led_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pll_locked;
    logic        pll_areset;
    logic        LED;

    int errors = 0;
    int checks = 0;

    pll_led_sequencer #(
        .RESET_CYCLES    (16),
        .LOCK_TIMEOUT    (1024),
        .CNT_W           (24),
        .HALF_PERIOD_RST (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .pll_locked (pll_locked),
        .pll_areset (pll_areset),
        .LED        (LED)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clock);
        write     = 1'b0;
        writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit);
        int cnt = 0;
        while (2'(dut.state) != s && cnt < limit) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (2'(dut.state) !== s) begin
            errors++;
            $display("FAIL wait_state: state=%0d expected %0d", 2'(dut.state), s);
        end
    endtask

    task automatic test_reset();
        int cnt = 0;
        reset = 1'b1; pll_locked = 1'b0; address = 2'd0;
        read = 1'b0; write = 1'b0; writedata = 32'd0;
        repeat (3) @(negedge clock);
        checks++;
        if (pll_areset !== 1'b1) begin errors++; $display("FAIL rst_areset: got %b expected 1", pll_areset); end
        checks++;
        if (LED !== 1'b0) begin errors++; $display("FAIL rst_led: got %b expected 0", LED); end
        checks++;
        if (readdata !== 32'd0) begin errors++; $display("FAIL rst_readdata: got %h expected 0", readdata); end
        reset = 1'b0;
        while (pll_areset === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt != 16) begin errors++; $display("FAIL areset_len: got %0d cycles expected 16", cnt); end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        logic [31:0] d;
        while (2'(dut.state) == 2'd1 && cnt < 2000) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt != 1024) begin errors++; $display("FAIL wait_len: got %0d cycles expected 1024", cnt); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0B) begin errors++; $display("FAIL status_fail: got %h expected 0000000b", d); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd10) begin errors++; $display("FAIL hp_reset: got %0d expected 10", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ctrl_reset: got %h expected 0", d); end
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL timeout_w1c: got %h expected 00000003", d); end
    endtask

    task automatic test_lock();
        bus_write(2'd0, 32'h2);
        checks++;
        if (2'(dut.state) !== 2'd0 || pll_areset !== 1'b1) begin
            errors++; $display("FAIL start_from_fail: state=%0d areset=%b expected 0/1", 2'(dut.state), pll_areset);
        end
        wait_state(2'd1, 100);
        repeat (5) @(negedge clock);
        pll_locked = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (2'(dut.state) !== 2'd1) begin errors++; $display("FAIL lock_early: state=%0d expected 1", 2'(dut.state)); end
        @(negedge clock);
        checks++;
        if (2'(dut.state) !== 2'd2) begin errors++; $display("FAIL lock_latency: state=%0d expected 2", 2'(dut.state)); end
    endtask

    task automatic test_blink();
        logic [31:0] d;
        logic        exp;
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            exp = ((k / 4) % 2) == 1;
            checks++;
            if (LED !== exp) begin errors++; $display("FAIL blink_k%0d: LED=%b expected %b", k, LED, exp); end
        end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL toggles_20: got %0d expected 5", d); end
    endtask

    task automatic test_half_zero();
        logic exp;
        bus_write(2'd2, 32'd0);
        exp = LED;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            exp = ~exp;
            checks++;
            if (LED !== exp) begin errors++; $display("FAIL hp0_k%0d: LED=%b expected %b", k, LED, exp); end
        end
    endtask

    task automatic test_lock_loss();
        logic [31:0] d;
        pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (2'(dut.state) !== 2'd0 || pll_areset !== 1'b1 || LED !== 1'b0) begin
            errors++;
            $display("FAIL lockloss: state=%0d areset=%b LED=%b expected 0/1/0", 2'(dut.state), pll_areset, LED);
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL lostlock_sticky: got %h expected 00000010", d); end
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL lostlock_w1c: got %h expected 0", d); end
    endtask

    task automatic test_timeout_race_and_fail_start();
        logic [31:0] d;
        wait_state(2'd1, 100);
        repeat (1023) @(negedge clock);
        bus_write(2'd1, 32'h08);
        checks++;
        if (2'(dut.state) !== 2'd3) begin errors++; $display("FAIL race_fail: state=%0d expected 3", 2'(dut.state)); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0B) begin errors++; $display("FAIL race_sticky: got %h expected 0000000b", d); end
        bus_read(2'd3, d);
        checks++;
        if (d === 32'd0) begin errors++; $display("FAIL toggles_kept: got %0d expected nonzero", d); end
        bus_write(2'd0, 32'h2);
        checks++;
        if (2'(dut.state) !== 2'd0 || pll_areset !== 1'b1) begin
            errors++; $display("FAIL fail_start: state=%0d areset=%b expected 0/1", 2'(dut.state), pll_areset);
        end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL toggles_clr: got %0d expected 0", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ctrl_start_rd: got %h expected 0", d); end
    endtask

    task automatic test_start_with_lockloss();
        logic [31:0] d;
        pll_locked = 1'b1;
        wait_state(2'd2, 200);
        pll_locked = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (2'(dut.state) !== 2'd2) begin errors++; $display("FAIL pre_race_run: state=%0d expected 2", 2'(dut.state)); end
        bus_write(2'd0, 32'h2);
        checks++;
        if (2'(dut.state) !== 2'd0) begin errors++; $display("FAIL start_race_state: state=%0d expected 0", 2'(dut.state)); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h18) begin errors++; $display("FAIL start_race_sticky: got %h expected 00000018", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        pll_locked = 1'b1;
        wait_state(2'd2, 200);
        bus_write(2'd0, 32'h1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (2'(dut.state) !== 2'd0 || pll_areset !== 1'b1 || LED !== 1'b0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d areset=%b LED=%b rd=%h expected 0/1/0/0",
                     2'(dut.state), pll_areset, LED, readdata);
        end
        reset = 1'b0;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd10) begin errors++; $display("FAIL mid_reset_hp: got %0d expected 10", d); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL mid_reset_status: got %h expected 0", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL mid_reset_ctrl: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_lock();
        test_blink();
        test_half_zero();
        test_lock_loss();
        test_timeout_race_and_fail_start();
        test_start_with_lockloss();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
